// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multicycle MIPS control unit and datapath
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
    ST_R_EX, ST_R_WB, ST_I_EX, ST_I_WB, ST_BRANCH, ST_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
  } ctrl_t;

  // States that wait on the memory ready handshake.
  function automatic logic is_mem_wait(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control-unit to datapath signal bundle
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             zf;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic             mem_timeout;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zf, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           illegal_op, mem_timeout, instr_count
  );

  modport slave (
    output opcode, zf, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           illegal_op, mem_timeout, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM with memory stall timeout and retire counter
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  multicycle_ctrl_if.master bus
);

  localparam int WW = $clog2(WAIT_MAX + 2);
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);
  localparam logic [WW-1:0] WAIT_PRE = WW'(WAIT_MAX - 1);
  localparam logic TIMEOUT_EN = (WAIT_MAX != 0);

  state_t           state, state_next;
  ctrl_t            ctrl;
  logic             is_store_q;
  logic [WW-1:0]    wait_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             stall;

  assign stall = is_mem_wait(state) && !bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RESET;
      is_store_q <= 1'b0;
    end else begin
      state <= state_next;
      // lw/sw is resolved here so later opcode changes cannot redirect MEM_ADDR.
      if (state == ST_DECODE) is_store_q <= (bus.opcode == OP_SW);
    end
  end

  always_comb begin
    state_next = state;
    ctrl       = '0;
    case (state)
      ST_RESET: state_next = ST_FETCH;
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        case (bus.opcode)
          OP_RTYPE:     state_next = ST_R_EX;
          OP_LW, OP_SW: state_next = ST_MEM_ADDR;
          OP_ADDI:      state_next = ST_I_EX;
          OP_BEQ:       state_next = ST_BRANCH;
          OP_J:         state_next = ST_JUMP;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_next      = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = is_store_q ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (bus.mem_ready) state_next = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_next      = ST_FETCH;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (bus.mem_ready) state_next = ST_FETCH;
      end
      ST_R_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
        state_next     = ST_R_WB;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_next     = ST_FETCH;
      end
      ST_I_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = ST_I_WB;
      end
      ST_I_WB: begin
        ctrl.reg_write = 1'b1;
        state_next     = ST_FETCH;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        state_next         = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        state_next     = ST_FETCH;
      end
      default: state_next = ST_RESET;
    endcase
    // Fires on the stalled cycle that carries the counter onto WAIT_MAX, so it pulses once.
    ctrl.mem_timeout = TIMEOUT_EN && stall && (wait_cnt == WAIT_PRE);
  end

  // Leaving a wait state always coincides with mem_ready, so clearing on any
  // non-stalled cycle also covers clearing on entry to the next wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (stall) begin
      if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + WW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
    end else if (state_next == ST_FETCH && state != ST_FETCH && state != ST_RESET) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.mem_timeout   = ctrl.mem_timeout;
  assign bus.instr_count   = instr_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
  } ov_t;

  typedef struct {
    string      tag;
    ov_t        ov;
    logic [2:0] cnt;
  } exp_t;

  localparam logic [5:0] JUNK = 6'h3f;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  logic [2:0] exp_cnt;
  int n_vec;
  int n_fail;

  multicycle_ctrl_if #(.CNT_W(3)) bus ();

  multicycle_ctrl #(.CNT_W(3), .WAIT_MAX(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ov_t f_zero();
    ov_t o;
    o = '0;
    return o;
  endfunction

  function automatic ov_t f_fetch(input logic rdy, input logic tmo);
    ov_t o;
    o = '0;
    o.mem_read = 1'b1; o.alu_src_b = 2'b01;
    o.ir_write = rdy; o.pc_write = rdy; o.mem_timeout = tmo;
    return o;
  endfunction

  function automatic ov_t f_dec(input logic ill);
    ov_t o;
    o = '0;
    o.alu_src_b = 2'b11; o.illegal_op = ill;
    return o;
  endfunction

  function automatic ov_t f_st(input int which);
    ov_t o;
    o = '0;
    case (which)
      0: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end              // MEM_ADDR / I_EX
      1: begin o.mem_read = 1'b1; o.iord = 1'b1; end                     // MEM_RD
      2: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end              // MEM_WB
      3: begin o.mem_write = 1'b1; o.iord = 1'b1; end                    // MEM_WR
      4: begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end                 // R_EX
      5: begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end                 // R_WB
      6: begin o.reg_write = 1'b1; end                                   // I_WB
      7: begin o.alu_src_a = 1'b1; o.alu_op = 2'b01;
               o.pc_write_cond = 1'b1; o.pc_source = 2'b01; end          // BRANCH
      default: begin o.pc_write = 1'b1; o.pc_source = 2'b10; end         // JUMP
    endcase
    return o;
  endfunction

  task automatic step(input string tag, input logic rn, input logic [5:0] op,
                      input logic rdy, input ov_t e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n         = rn;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    x.tag = tag;
    x.ov  = e;
    x.cnt = exp_cnt;
    exp_q.push_back(x);
  endtask

  // Monitor: every cycle carrying an expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      ov_t act;
      e   = exp_q.pop_front();
      act = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
             bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
             bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op, bus.mem_timeout};
      n_vec++;
      if (act !== e.ov || bus.instr_count !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: got ctrl=%05h count=%0d, want ctrl=%05h count=%0d",
                 e.tag, act, bus.instr_count, e.ov, e.cnt);
      end
    end
  end

  initial begin
    n_vec         = 0;
    n_fail        = 0;
    exp_cnt       = 3'd0;
    rst_n         = 1'b0;
    bus.opcode    = 6'd0;
    bus.zf        = 1'b0;
    bus.mem_ready = 1'b0;

    step("reset_a", 1'b0, JUNK, 1'b0, f_zero());
    step("reset_b", 1'b0, JUNK, 1'b1, f_zero());
    step("reset_state", 1'b1, JUNK, 1'b1, f_zero());

    // R-type
    step("r_fetch", 1'b1, JUNK, 1'b1, f_fetch(1'b1, 1'b0));
    step("r_decode", 1'b1, OP_RTYPE, 1'b1, f_dec(1'b0));
    step("r_ex", 1'b1, JUNK, 1'b1, f_st(4));
    step("r_wb", 1'b1, JUNK, 1'b1, f_st(5));
    exp_cnt++;

    // lw with three stalled cycles in MEM_RD
    step("lw_fetch", 1'b1, JUNK, 1'b1, f_fetch(1'b1, 1'b0));
    step("lw_decode", 1'b1, OP_LW, 1'b1, f_dec(1'b0));
    step("lw_addr", 1'b1, OP_SW, 1'b1, f_st(0));
    for (int i = 0; i < 3; i++) step("lw_rd_stall", 1'b1, JUNK, 1'b0, f_st(1));
    step("lw_rd_done", 1'b1, JUNK, 1'b1, f_st(1));
    step("lw_wb", 1'b1, JUNK, 1'b1, f_st(2));
    exp_cnt++;

    // sw
    step("sw_fetch", 1'b1, JUNK, 1'b1, f_fetch(1'b1, 1'b0));
    step("sw_decode", 1'b1, OP_SW, 1'b1, f_dec(1'b0));
    step("sw_addr", 1'b1, OP_LW, 1'b1, f_st(0));
    step("sw_wr", 1'b1, JUNK, 1'b1, f_st(3));
    exp_cnt++;

    // addi
    step("addi_fetch", 1'b1, JUNK, 1'b1, f_fetch(1'b1, 1'b0));
    step("addi_decode", 1'b1, OP_ADDI, 1'b1, f_dec(1'b0));
    step("addi_ex", 1'b1, JUNK, 1'b1, f_st(0));
    step("addi_wb", 1'b1, JUNK, 1'b1, f_st(6));
    exp_cnt++;

    // beq
    step("beq_fetch", 1'b1, JUNK, 1'b1, f_fetch(1'b1, 1'b0));
    step("beq_decode", 1'b1, OP_BEQ, 1'b1, f_dec(1'b0));
    step("beq_branch", 1'b1, JUNK, 1'b1, f_st(7));
    exp_cnt++;

    // j
    step("j_fetch", 1'b1, JUNK, 1'b1, f_fetch(1'b1, 1'b0));
    step("j_decode", 1'b1, OP_J, 1'b1, f_dec(1'b0));
    step("j_jump", 1'b1, JUNK, 1'b1, f_st(8));
    exp_cnt++;

    // illegal opcode retires straight from DECODE
    step("ill_fetch", 1'b1, JUNK, 1'b1, f_fetch(1'b1, 1'b0));
    step("ill_decode", 1'b1, 6'b111111, 1'b1, f_dec(1'b1));
    exp_cnt++;

    // 20 stalled fetch cycles: single timeout pulse on the 15th
    for (int k = 1; k <= 20; k++)
      step("fetch_stall", 1'b1, JUNK, 1'b0, f_fetch(1'b0, (k == 15)));
    step("fetch_release", 1'b1, JUNK, 1'b1, f_fetch(1'b1, 1'b0));
    step("stall_r_decode", 1'b1, OP_RTYPE, 1'b0, f_dec(1'b0));
    step("stall_r_ex", 1'b1, JUNK, 1'b0, f_st(4));
    step("stall_r_wb", 1'b1, JUNK, 1'b0, f_st(5));
    exp_cnt++;  // eighth retirement: 3-bit counter wraps to 0

    step("wrap_j_fetch", 1'b1, JUNK, 1'b1, f_fetch(1'b1, 1'b0));
    step("wrap_j_decode", 1'b1, OP_J, 1'b1, f_dec(1'b0));
    step("wrap_j_jump", 1'b1, JUNK, 1'b1, f_st(8));
    exp_cnt++;

    // abort a stalled sw with reset
    step("ab_fetch", 1'b1, JUNK, 1'b1, f_fetch(1'b1, 1'b0));
    step("ab_decode", 1'b1, OP_SW, 1'b1, f_dec(1'b0));
    step("ab_addr", 1'b1, JUNK, 1'b0, f_st(0));
    step("ab_wr_stall", 1'b1, JUNK, 1'b0, f_st(3));
    exp_cnt = 3'd0;
    step("ab_reset", 1'b0, JUNK, 1'b1, f_zero());
    step("ab_reset_hold", 1'b0, JUNK, 1'b1, f_zero());
    step("ab_reset_state", 1'b1, JUNK, 1'b1, f_zero());
    step("post_fetch", 1'b1, JUNK, 1'b1, f_fetch(1'b1, 1'b0));
    step("post_decode", 1'b1, OP_J, 1'b1, f_dec(1'b0));
    step("post_jump", 1'b1, JUNK, 1'b1, f_st(8));
    exp_cnt++;
    step("post_fetch_wait", 1'b1, JUNK, 1'b0, f_fetch(1'b0, 1'b0));

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
